// File: rtl/stage_sequencer.sv
// stage_sequencer: N-stage flow sequencer with per-stage advance events, back, inactivity timeout and wrap.
// Stage 0 is IDLE; stages 1..N_STAGES-1 are user stages.
module stage_sequencer #(
    parameter int                    N_STAGES    = 6,
    parameter int                    N_EVT       = 4,
    parameter logic [4*N_STAGES-1:0] ADV_SEL     = 24'hF0100F,
    parameter int                    TIMEOUT_CYC = 0,
    parameter bit                    WRAP        = 0,
    parameter int                    SW          = $clog2(N_STAGES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [N_EVT-1:0]    evt,
    input  logic                back,
    output logic [SW-1:0]       state,
    output logic [N_STAGES-1:0] state_onehot,
    output logic                stage_entry,
    output logic                timeout_flag,
    output logic                enable_falling
);
    localparam int            CW   = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [SW-1:0] LAST = SW'(N_STAGES - 1);

    logic             enable_d, back_d;
    logic [N_EVT-1:0] evt_d, evt_rise;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    next_state;
    logic [3:0]       sel;
    logic             enable_rise, back_rise, clr_edge, in_range, mid_stage, expire, adv;

    assign enable_rise    = enable & ~enable_d;
    assign enable_falling = ~enable & enable_d;
    assign back_rise      = back & ~back_d;
    assign evt_rise       = evt & ~evt_d;
    assign clr_edge       = back_rise | (|evt_rise);
    assign in_range       = {1'b0, state} < (SW + 1)'(N_STAGES);
    assign mid_stage      = in_range && state != '0 && state != LAST;
    assign expire         = TIMEOUT_CYC > 0 && mid_stage && !clr_edge && cnt == CW'(TIMEOUT_CYC - 1);
    assign state_onehot   = N_STAGES'(1) << state;

    // Advance event of the current stage; a field >= N_EVT never matches
    always_comb begin
        sel = 4'hF;
        for (int i = 1; i < N_STAGES; i++)
            if (state == SW'(i)) sel = ADV_SEL[4*i +: 4];
        adv = 1'b0;
        for (int j = 0; j < N_EVT; j++)
            if (sel == 4'(j) && evt_rise[j]) adv = 1'b1;
    end

    always_comb begin
        next_state = !in_range                 ? '0 :
                     state == '0               ? (enable_rise ? SW'(1) : '0) :
                     enable_falling || expire  ? '0 :
                     back_rise                 ? (state > SW'(1) ? state - SW'(1) : state) :
                     adv                       ? (state != LAST ? state + SW'(1) : (WRAP ? SW'(1) : state)) :
                                                 state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= '0;
            stage_entry  <= 1'b0;
            timeout_flag <= 1'b0;
            enable_d     <= 1'b0;
            evt_d        <= '0;
            back_d       <= 1'b0;
            cnt          <= '0;
        end else begin
            state        <= next_state;
            stage_entry  <= next_state != state;
            timeout_flag <= expire && !enable_falling;
            enable_d     <= enable;
            evt_d        <= evt;
            back_d       <= back;
            cnt          <= (TIMEOUT_CYC == 0 || !mid_stage || next_state != state || clr_edge) ? '0 :
                            (cnt == CW'(TIMEOUT_CYC) ? cnt : cnt + CW'(1));
        end
    end
endmodule
